// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard.
// Latency classes used by the decoder when driving i_lat.
package hazard_scoreboard_pkg;

    localparam int DEF_MAX_LAT = 7;

    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_MUL  = 3;
    localparam int LAT_DIV  = DEF_MAX_LAT;

endpackage

// File: rtl/sb_counter.sv
// Per-register scoreboard counter.
// Hold has priority over load, load over decrement; stops at zero.
module sb_counter #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic [LAT_W-1:0] cnt
);

    // Count down remaining forwarding latency for one register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (hold) begin
            cnt <= cnt;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW/WAW hazard scoreboard beside the ID stage.
// Produces stall/issue and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int MAX_LAT  = DEF_MAX_LAT,
    parameter int LAT_W    = $clog2(MAX_LAT + 1),
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_issueValid,
    input  logic [REG_AW-1:0]   i_rs1,
    input  logic                i_rs1Used,
    input  logic [REG_AW-1:0]   i_rs2,
    input  logic                i_rs2Used,
    input  logic [REG_AW-1:0]   i_rd,
    input  logic                i_rdWrite,
    input  logic [LAT_W-1:0]    i_lat,
    input  logic                i_flush,
    input  logic                i_hold,
    output logic                o_stall,
    output logic                o_issue,
    output logic [NUM_REGS-1:0] o_pending,
    output logic [CNT_W-1:0]    o_stallCount
);

    localparam int NSLOT = 2 ** REG_AW;

    // Every index slot exists; x0 and indices past NUM_REGS read as zero
    logic [LAT_W-1:0] cnt [NSLOT];
    logic [LAT_W-1:0] lat_sat;
    logic [LAT_W-1:0] rs1_cnt;
    logic [LAT_W-1:0] rs2_cnt;
    logic [LAT_W-1:0] rd_cnt;
    logic             raw1;
    logic             raw2;
    logic             waw;
    logic             issue_wr;

    assign lat_sat = (i_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : i_lat;

    assign rs1_cnt = cnt[i_rs1];
    assign rs2_cnt = cnt[i_rs2];
    assign rd_cnt  = cnt[i_rd];

    assign raw1 = i_rs1Used & (i_rs1 != '0) & (rs1_cnt != '0);
    assign raw2 = i_rs2Used & (i_rs2 != '0) & (rs2_cnt != '0);
    // Younger write must not retire before the older one
    assign waw  = i_rdWrite & (i_rd != '0) & (rd_cnt > lat_sat);

    assign o_stall  = i_issueValid & ~i_flush & (raw1 | raw2 | waw);
    assign o_issue  = i_issueValid & ~i_flush & ~o_stall & ~i_hold;
    assign issue_wr = o_issue & i_rdWrite & (i_rd != '0);

    for (genvar r = 0; r < NSLOT; r++) begin : g_reg
        if (r == 0 || r >= NUM_REGS) begin : g_none
            assign cnt[r] = '0;
        end else begin : g_cnt
            sb_counter #(
                .LAT_W    (LAT_W)
            ) u_cnt (
                .clk      (clk),
                .reset    (reset),
                .hold     (i_hold),
                .load     (issue_wr && (i_rd == REG_AW'(r))),
                .load_val (lat_sat),
                .cnt      (cnt[r])
            );
        end
        if (r < NUM_REGS) begin : g_pend
            assign o_pending[r] = (cnt[r] != '0);
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_stallCount <= '0;
        end else if (o_stall && !(&o_stallCount)) begin
            o_stallCount <= o_stallCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard.
// Small CNT_W and MAX_LAT=6 expose saturation and latency clamping.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic        clk;
    logic        reset;
    logic        i_issueValid;
    logic [4:0]  i_rs1;
    logic        i_rs1Used;
    logic [4:0]  i_rs2;
    logic        i_rs2Used;
    logic [4:0]  i_rd;
    logic        i_rdWrite;
    logic [2:0]  i_lat;
    logic        i_flush;
    logic        i_hold;
    logic        o_stall;
    logic        o_issue;
    logic [31:0] o_pending;
    logic [3:0]  o_stallCount;

    int checks = 0;
    int errors = 0;
    int st;

    hazard_scoreboard #(
        .NUM_REGS     (32),
        .REG_AW       (5),
        .MAX_LAT      (6),
        .CNT_W        (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_issueValid (i_issueValid),
        .i_rs1        (i_rs1),
        .i_rs1Used    (i_rs1Used),
        .i_rs2        (i_rs2),
        .i_rs2Used    (i_rs2Used),
        .i_rd         (i_rd),
        .i_rdWrite    (i_rdWrite),
        .i_lat        (i_lat),
        .i_flush      (i_flush),
        .i_hold       (i_hold),
        .o_stall      (o_stall),
        .o_issue      (o_issue),
        .o_pending    (o_pending),
        .o_stallCount (o_stallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_issueValid = 1'b0;
        i_rs1 = '0; i_rs1Used = 1'b0;
        i_rs2 = '0; i_rs2Used = 1'b0;
        i_rd = '0; i_rdWrite = 1'b0;
        i_lat = '0; i_flush = 1'b0; i_hold = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Present one instruction until it issues; returns stalled cycles
    task automatic issue_op(input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2,
                            input logic [4:0] rd, input logic w,
                            input logic [2:0] lat, input int hold_n,
                            output int stalls);
        bit done;
        done = 1'b0;
        stalls = 0;
        i_issueValid = 1'b1;
        i_rs1 = rs1; i_rs1Used = u1;
        i_rs2 = rs2; i_rs2Used = u2;
        i_rd = rd; i_rdWrite = w; i_lat = lat;
        for (int k = 0; k < 60 && !done; k++) begin
            i_hold = (k < hold_n);
            #1;
            if (o_issue) done = 1'b1;
            else if (o_stall) stalls++;
            @(posedge clk);
            #1;
        end
        idle();
        if (!done) chk("issue_timeout", 0, 1);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #1;
        chk("rst_pending", o_pending, 0);
        chk("rst_count", o_stallCount, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_issue", o_issue, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // load-use: exactly one bubble
        issue_op(5'd0, 0, 5'd0, 0, 5'd5, 1, 3'(LAT_LOAD), 0, st);
        chk("ld_stalls", st, 0);
        issue_op(5'd5, 1, 5'd1, 1, 5'd6, 1, 3'(LAT_ALU), 0, st);
        chk("use_stalls", st, 1);
        chk("use_count", o_stallCount, 1);
        chk("use_pending", o_pending, 0);

        // multi-cycle producer, then with two hold cycles
        issue_op(5'd0, 0, 5'd0, 0, 5'd7, 1, 3'(LAT_MUL), 0, st);
        issue_op(5'd7, 1, 5'd0, 0, 5'd2, 1, 3'd0, 0, st);
        chk("mul_stalls", st, 3);
        issue_op(5'd0, 0, 5'd0, 0, 5'd7, 1, 3'(LAT_MUL), 0, st);
        issue_op(5'd0, 0, 5'd7, 1, 5'd2, 1, 3'd0, 2, st);
        chk("mul_hold_stalls", st, 5);
        chk("mul_count", o_stallCount, 9);

        pulse_reset();
        // lat=0 chain never stalls
        issue_op(5'd0, 1, 5'd0, 0, 5'd3, 1, 3'd0, 0, st);
        chk("alu_pending", o_pending, 0);
        issue_op(5'd3, 1, 5'd3, 1, 5'd4, 1, 3'd0, 0, st);
        chk("alu_stalls", st, 0);

        // WAW: younger lat=0 write waits for older lat=3
        issue_op(5'd0, 0, 5'd0, 0, 5'd8, 1, 3'd3, 0, st);
        chk("waw_pend", o_pending, 32'h100);
        issue_op(5'd0, 0, 5'd0, 0, 5'd8, 1, 3'd0, 0, st);
        chk("waw_stalls", st, 3);
        chk("waw_pend_after", o_pending, 0);
        chk("waw_count", o_stallCount, 3);

        // reset mid-stall clears everything at once
        issue_op(5'd0, 0, 5'd0, 0, 5'd9, 1, 3'd5, 0, st);
        chk("x9_pend", o_pending, 32'h200);
        i_issueValid = 1'b1; i_rs1 = 5'd9; i_rs1Used = 1'b1;
        #1;
        chk("x9_stall", o_stall, 1);
        reset = 1'b1;
        #1;
        chk("arst_pending", o_pending, 0);
        chk("arst_count", o_stallCount, 0);
        chk("arst_stall", o_stall, 0);
        reset = 1'b0;
        idle();
        @(posedge clk);
        #1;

        // x0, unused source, flush
        issue_op(5'd0, 0, 5'd0, 0, 5'd10, 1, 3'd3, 0, st);
        issue_op(5'd0, 1, 5'd0, 1, 5'd0, 1, 3'd5, 0, st);
        chk("x0_stalls", st, 0);
        chk("x0_pend", o_pending, 32'h400);
        issue_op(5'd10, 0, 5'd0, 0, 5'd12, 0, 3'd0, 0, st);
        chk("unused_stalls", st, 0);
        i_issueValid = 1'b1; i_rs1 = 5'd10; i_rs1Used = 1'b1;
        i_rd = 5'd11; i_rdWrite = 1'b1; i_lat = 3'd5; i_flush = 1'b1;
        #1;
        chk("flush_stall", o_stall, 0);
        chk("flush_issue", o_issue, 0);
        @(posedge clk);
        #1;
        idle();
        chk("flush_pend", o_pending, 0);
        chk("flush_count", o_stallCount, 0);

        // latency clamp to 6, then saturation under a long hold
        issue_op(5'd0, 0, 5'd0, 0, 5'd9, 1, 3'd7, 0, st);
        issue_op(5'd9, 1, 5'd0, 0, 5'd1, 1, 3'd0, 0, st);
        chk("clamp_stalls", st, 6);
        issue_op(5'd0, 0, 5'd0, 0, 5'd9, 1, 3'd7, 0, st);
        issue_op(5'd9, 1, 5'd0, 0, 5'd1, 1, 3'd0, 30, st);
        chk("sat_stalls", st, 36);
        chk("sat_count", o_stallCount, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
